rst_sequencer: RTL and testbench

//   Top-level reset sequencer. Takes the raw push-button/power-on reset and releases
//   NUM_DOM downstream reset domains one at a time, in index order, once the reset is clean.

---
 rtl/rst_seq_pkg.sv | 32 +++
 rtl/rst_sync2.sv | 24 ++
 rtl/rst_sequencer.sv | 160 ++++++++++++++++
 tb/tb_rst_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
//   rst_seq_state_e : sequencer FSM states
//   cnt_w(a,b,c)    : width of a counter that must hold max(a,b,c)
package rst_seq_pkg;

    typedef enum logic [2:0] {
        SYNC      = 3'd0,
        STRETCH   = 3'd1,
        WAIT_LOCK = 3'd2,
        STAGE     = 3'd3,
        DONE      = 3'd4,
        SW_HOLD   = 3'd5
    } rst_seq_state_e;

    // Width needed to hold the largest of three cycle counts without wrapping.
    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_sync2.sv
// Two-flop reset synchroniser: asserts asynchronously, releases synchronously.
//   clk    in  : destination clock
//   arst_n in  : raw asynchronous active-low reset
//   sync_n out : synchronised active-low reset, high on the 2nd edge after arst_n rises
module rst_sync2 (
    input  logic clk,
    input  logic arst_n,
    output logic sync_n
);

    logic meta_r;

    // Shift a constant 1 through two flops; both clear immediately on arst_n low.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            meta_r <= 1'b0;
            sync_n <= 1'b0;
        end else begin
            meta_r <= 1'b1;
            sync_n <= meta_r;
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: releases NUM_DOM reset domains one at a time, in index order,
// after the raw reset has been synchronised, stretched and the PLL has locked.
//   clk        in  : system clock
//   RST_n      in  : raw asynchronous active-low reset (button / power-on)
//   pll_lock   in  : PLL lock, synchronous to clk
//   sw_rst_req in  : one-cycle software reset request
//   rst_n_out  out : per-domain active-low resets, bit 0 released first
//   seq_done   out : all domains released
//   busy       out : sequencer not in DONE
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOM     = 3,
    parameter int STRETCH_CYC = 16,
    parameter int STAGE_GAP   = 4,
    parameter int SW_HOLD_CYC = 8
) (
    input  logic               clk,
    input  logic               RST_n,
    input  logic               pll_lock,
    input  logic               sw_rst_req,
    output logic [NUM_DOM-1:0] rst_n_out,
    output logic               seq_done,
    output logic               busy
);

    localparam int CW = cnt_w(STRETCH_CYC, STAGE_GAP, SW_HOLD_CYC);
    localparam int IW = $clog2(NUM_DOM + 1);

    localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(SW_HOLD_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DOM - 1);

    logic           sync_n;
    rst_seq_state_e state_r;
    logic [CW-1:0]  cnt_r;
    logic [IW-1:0]  idx_r;

    rst_sync2 u_sync (
        .clk    (clk),
        .arst_n (RST_n),
        .sync_n (sync_n)
    );

    // Sequencer FSM with registered domain resets and status flags.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_r   <= SYNC;
            cnt_r     <= '0;
            idx_r     <= '0;
            rst_n_out <= '0;
            seq_done  <= 1'b0;
            busy      <= 1'b1;
        end else if (sw_rst_req) begin
            // Software request beats lock loss and any release due this cycle.
            state_r   <= SW_HOLD;
            cnt_r     <= '0;
            idx_r     <= '0;
            rst_n_out <= '0;
            seq_done  <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state_r)
                SYNC: begin
                    // The cycle in which sync_n is first seen high is already
                    // one stable-high cycle, so the stretch count starts at 1.
                    if (sync_n) begin
                        if (STRETCH_CYC == 1) begin
                            state_r <= WAIT_LOCK;
                            cnt_r   <= '0;
                        end else begin
                            state_r <= STRETCH;
                            cnt_r   <= CW'(1);
                        end
                    end else begin
                        state_r <= SYNC;
                    end
                end
                STRETCH: begin
                    if (cnt_r == STRETCH_LAST) begin
                        state_r <= WAIT_LOCK;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (pll_lock) begin
                        rst_n_out <= NUM_DOM'(1);
                        cnt_r     <= '0;
                        idx_r     <= IW'(1);
                        if (NUM_DOM == 1) begin
                            state_r  <= DONE;
                            seq_done <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            state_r <= STAGE;
                        end
                    end else begin
                        state_r <= WAIT_LOCK;
                    end
                end
                STAGE: begin
                    if (!pll_lock) begin
                        state_r   <= WAIT_LOCK;
                        cnt_r     <= '0;
                        idx_r     <= '0;
                        rst_n_out <= '0;
                        seq_done  <= 1'b0;
                        busy      <= 1'b1;
                    end else if (cnt_r == GAP_LAST) begin
                        // Shifting in a 1 keeps the output a low-bits-set prefix.
                        rst_n_out <= (rst_n_out << 1) | NUM_DOM'(1);
                        cnt_r     <= '0;
                        idx_r     <= idx_r + IW'(1);
                        if (idx_r == IDX_LAST) begin
                            state_r  <= DONE;
                            seq_done <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            state_r <= STAGE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    if (!pll_lock) begin
                        state_r   <= WAIT_LOCK;
                        cnt_r     <= '0;
                        idx_r     <= '0;
                        rst_n_out <= '0;
                        seq_done  <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        state_r <= DONE;
                    end
                end
                SW_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_r <= STRETCH;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r   <= SYNC;
                    cnt_r     <= '0;
                    idx_r     <= '0;
                    rst_n_out <= '0;
                    seq_done  <= 1'b0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer (NUM_DOM=3, STRETCH=16, GAP=4, HOLD=8).
// A timestamp-based model predicts how many domains are released; a compare
// process checks the DUT every cycle, and directed scenarios pin exact edges.
module tb_rst_sequencer;

    localparam int N = 3;
    localparam int S = 16;
    localparam int G = 4;
    localparam int H = 8;

    logic         clk;
    logic         RST_n;
    logic         pll_lock;
    logic         sw_rst_req;
    logic [N-1:0] rst_n_out;
    logic         seq_done;
    logic         busy;

    int errors = 0;
    int checks = 0;

    // Model state: absolute edge number, released-domain count, timing marks.
    int ecnt  = 0;
    int nrel  = 0;
    int r0    = 0;
    int ready = 1000000;

    rst_sequencer #(
        .NUM_DOM     (N),
        .STRETCH_CYC (S),
        .STAGE_GAP   (G),
        .SW_HOLD_CYC (H)
    ) dut (
        .clk        (clk),
        .RST_n      (RST_n),
        .pll_lock   (pll_lock),
        .sw_rst_req (sw_rst_req),
        .rst_n_out  (rst_n_out),
        .seq_done   (seq_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: bit 0 may release at the first lock-high edge at or
    // after 'ready'; bit i follows i*G edges later.
    always @(posedge clk) begin
        ecnt = ecnt + 1;
        if (RST_n) begin
            if (sw_rst_req) begin
                nrel  = 0;
                ready = ecnt + H + S + 1;
            end else if (nrel > 0 && !pll_lock) begin
                nrel  = 0;
                ready = ecnt + 1;
            end else if (nrel == 0) begin
                if (ecnt >= ready && pll_lock) begin
                    nrel = 1;
                    r0   = ecnt;
                end
            end else if (nrel < N && ecnt == r0 + nrel * G) begin
                nrel = nrel + 1;
            end
        end
    end

    always @(negedge RST_n) nrel = 0;
    always @(posedge RST_n) ready = ecnt + 3 + S;

    function automatic logic [N-1:0] exp_vec(input int k);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (i < k);
        return v;
    endfunction

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at edge %0d: got %b expected %b", name, ecnt, got, exp);
        end
    endtask

    // Every-cycle comparison against the model plus the prefix-shape rule.
    always @(negedge clk) begin
        chk("model_rst_n_out", rst_n_out, exp_vec(nrel));
        chk("model_seq_done", {{(N-1){1'b0}}, seq_done}, {{(N-1){1'b0}}, (nrel == N)});
        chk("model_busy", {{(N-1){1'b0}}, busy}, {{(N-1){1'b0}}, (nrel != N)});
        chk("prefix_shape", {{(N-1){1'b0}}, ((rst_n_out & (rst_n_out + N'(1))) == '0)},
            {{(N-1){1'b0}}, 1'b1});
    end

    task automatic at_edge(input int t);
        while (ecnt < t) @(negedge clk);
    endtask

    task automatic glitch_rst();
        #1 RST_n = 1'b0;
        #1;
        chk("async_assert_out", rst_n_out, 3'b000);
        chk("async_assert_busy", {2'b00, busy}, 3'b001);
        chk("async_assert_done", {2'b00, seq_done}, 3'b000);
        #1 RST_n = 1'b1;
    endtask

    int k;

    initial begin
        RST_n      = 1'b1;
        pll_lock   = 1'b1;
        sw_rst_req = 1'b0;
        #1 RST_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out", rst_n_out, 3'b000);
        chk("reset_busy", {2'b00, busy}, 3'b001);

        // 1: clean power-up with lock already high.
        RST_n = 1'b1;
        k = ecnt;
        at_edge(k + 18); chk("t1_e18", rst_n_out, 3'b000);
        at_edge(k + 19); chk("t1_e19", rst_n_out, 3'b001);
        at_edge(k + 22); chk("t1_e22", rst_n_out, 3'b001);
        at_edge(k + 23); chk("t1_e23", rst_n_out, 3'b011);
        at_edge(k + 26); chk("t1_e26_done", {2'b00, seq_done}, 3'b000);
        at_edge(k + 27); chk("t1_e27", rst_n_out, 3'b111);
        chk("t1_done", {2'b00, seq_done}, 3'b001);
        chk("t1_busy", {2'b00, busy}, 3'b000);

        // 2: short glitch in DONE restarts the whole sequence.
        at_edge(k + 30);
        glitch_rst();
        k = ecnt;
        at_edge(k + 18); chk("t2_e18", rst_n_out, 3'b000);
        at_edge(k + 19); chk("t2_e19", rst_n_out, 3'b001);
        at_edge(k + 27); chk("t2_e27", rst_n_out, 3'b111);

        // 3: lock low until edge 40.
        pll_lock = 1'b0;
        glitch_rst();
        k = ecnt;
        at_edge(k + 40); chk("t3_e40", rst_n_out, 3'b000);
        pll_lock = 1'b1;
        at_edge(k + 41); chk("t3_e41", rst_n_out, 3'b001);
        at_edge(k + 45); chk("t3_e45", rst_n_out, 3'b011);
        at_edge(k + 49); chk("t3_e49", rst_n_out, 3'b111);

        // 4: software reset from DONE; sampled at edge k.
        at_edge(k + 52);
        sw_rst_req = 1'b1;
        k = ecnt + 1;
        at_edge(k); sw_rst_req = 1'b0;
        chk("t4_sw_out", rst_n_out, 3'b000);
        chk("t4_sw_busy", {2'b00, busy}, 3'b001);
        at_edge(k + 24); chk("t4_e24", rst_n_out, 3'b000);
        at_edge(k + 25); chk("t4_e25", rst_n_out, 3'b001);
        at_edge(k + 29); chk("t4_e29", rst_n_out, 3'b011);

        // 5: lock drops while 011.
        pll_lock = 1'b0;
        at_edge(k + 30); chk("t5_drop", rst_n_out, 3'b000);
        pll_lock = 1'b1;
        at_edge(k + 31); chk("t5_e31", rst_n_out, 3'b001);
        at_edge(k + 35); chk("t5_e35", rst_n_out, 3'b011);
        at_edge(k + 39); chk("t5_e39", rst_n_out, 3'b111);

        // 6: sw request and lock loss together; sw must win.
        at_edge(k + 42);
        sw_rst_req = 1'b1;
        pll_lock   = 1'b0;
        k = ecnt + 1;
        at_edge(k);
        sw_rst_req = 1'b0;
        pll_lock   = 1'b1;
        chk("t6_sw_out", rst_n_out, 3'b000);
        at_edge(k + 2);  chk("t6_no_early", rst_n_out, 3'b000);
        at_edge(k + 24); chk("t6_e24", rst_n_out, 3'b000);
        at_edge(k + 25); chk("t6_e25", rst_n_out, 3'b001);
        at_edge(k + 33); chk("t6_e33", rst_n_out, 3'b111);

        // Randomised phase: lock flaps, sw pulses, reset glitches.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            sw_rst_req = ($urandom_range(0, 249) == 0);
            if (pll_lock) begin
                if ($urandom_range(0, 79) == 0) pll_lock = 1'b0;
            end else begin
                if ($urandom_range(0, 9) == 0) pll_lock = 1'b1;
            end
            if ($urandom_range(0, 699) == 0) glitch_rst();
        end
        @(negedge clk);
        sw_rst_req = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
